// File: rtl/pipeline_mode_ctrl.sv
// Pipeline mode controller: derives global stall/flush controls from memory readiness,
// redirects, writeback collisions and instruction-load requests.
module pipeline_mode_ctrl #(
    parameter int FLUSH_CYCLES    = 3,
    parameter int MEMWAIT_TIMEOUT = 1024,
    parameter int STALL_CNT_W     = 16,
    parameter bit BOOT_LOAD       = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branch_jump,
    input  logic                   ram_ready,
    input  logic                   reg_write_collision,
    input  logic                   load_req,
    input  logic                   load_done,
    output logic                   master_hold,
    output logic                   flush_hold,
    output logic                   load_active,
    output logic                   timeout_err,
    output logic [1:0]             mode,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WAIT_W  = $clog2(MEMWAIT_TIMEOUT + 1);

    localparam logic [FLUSH_W-1:0]     FLUSH_INIT = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [FLUSH_W-1:0]     FLUSH_ZERO = {FLUSH_W{1'b0}};
    localparam logic [WAIT_W-1:0]      WAIT_MAX   = WAIT_W'(MEMWAIT_TIMEOUT);
    localparam logic [WAIT_W-1:0]      WAIT_ZERO  = {WAIT_W{1'b0}};
    localparam logic [STALL_CNT_W-1:0] STALL_MAX  = {STALL_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        MODE_RUN     = 2'b00,
        MODE_FLUSH   = 2'b01,
        MODE_MEMWAIT = 2'b10,
        MODE_LOAD    = 2'b11
    } modeT;

    localparam modeT RESET_MODE = BOOT_LOAD ? MODE_LOAD : MODE_RUN;

    modeT                   modeR, modeNextS;
    logic [FLUSH_W-1:0]     flushCtrR, flushCtrNextS;
    logic [WAIT_W-1:0]      waitCtrR, waitCtrNextS, waitIncS;
    logic                   pendingFlushR, pendingFlushNextS;
    logic                   timeoutErrR, timeoutErrNextS;
    logic [STALL_CNT_W-1:0] stallCntR;
    logic                   holdS;

    // Hold reacts in the same cycle to memory and writeback conflicts.
    assign holdS = ~ram_ready | reg_write_collision
                 | (modeR == MODE_MEMWAIT) | (modeR == MODE_LOAD);

    assign waitIncS = (waitCtrR == WAIT_MAX) ? WAIT_MAX : waitCtrR + WAIT_W'(1);

    assign master_hold  = holdS;
    assign flush_hold   = (modeR == MODE_FLUSH);
    assign load_active  = (modeR == MODE_LOAD);
    assign timeout_err  = timeoutErrR;
    assign mode         = modeR;
    assign stall_cycles = stallCntR;

    // Next-state and counter update logic.
    always_comb begin
        modeNextS         = modeR;
        flushCtrNextS     = flushCtrR;
        waitCtrNextS      = waitCtrR;
        pendingFlushNextS = pendingFlushR;
        timeoutErrNextS   = timeoutErrR;
        case (modeR)
            MODE_RUN: begin
                if (load_req) begin
                    modeNextS = MODE_LOAD;
                end else if (!ram_ready) begin
                    // A redirect that arrives behind a memory wait is replayed afterwards.
                    modeNextS         = MODE_MEMWAIT;
                    pendingFlushNextS = branch_jump;
                    waitCtrNextS      = WAIT_ZERO;
                end else if (branch_jump) begin
                    modeNextS     = MODE_FLUSH;
                    flushCtrNextS = FLUSH_INIT;
                end else begin
                    modeNextS = MODE_RUN;
                end
            end
            MODE_FLUSH: begin
                if (ram_ready) begin
                    if (flushCtrR == FLUSH_ZERO) begin
                        modeNextS = load_req ? MODE_LOAD : MODE_RUN;
                    end else begin
                        flushCtrNextS = flushCtrR - FLUSH_W'(1);
                    end
                end else begin
                    flushCtrNextS = flushCtrR;
                end
            end
            MODE_MEMWAIT: begin
                if (ram_ready) begin
                    if (pendingFlushR || branch_jump) begin
                        modeNextS     = MODE_FLUSH;
                        flushCtrNextS = FLUSH_INIT;
                    end else begin
                        modeNextS = MODE_RUN;
                    end
                    pendingFlushNextS = 1'b0;
                    waitCtrNextS      = WAIT_ZERO;
                end else begin
                    waitCtrNextS      = waitIncS;
                    pendingFlushNextS = pendingFlushR | branch_jump;
                    if (waitIncS == WAIT_MAX) begin
                        timeoutErrNextS = 1'b1;
                    end else begin
                        timeoutErrNextS = timeoutErrR;
                    end
                end
            end
            MODE_LOAD: begin
                if (load_done) begin
                    modeNextS     = MODE_FLUSH;
                    flushCtrNextS = FLUSH_INIT;
                end else begin
                    modeNextS = MODE_LOAD;
                end
            end
            default: begin
                modeNextS = MODE_RUN;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            modeR         <= RESET_MODE;
            flushCtrR     <= FLUSH_ZERO;
            waitCtrR      <= WAIT_ZERO;
            pendingFlushR <= 1'b0;
            timeoutErrR   <= 1'b0;
        end else begin
            modeR         <= modeNextS;
            flushCtrR     <= flushCtrNextS;
            waitCtrR      <= waitCtrNextS;
            pendingFlushR <= pendingFlushNextS;
            timeoutErrR   <= timeoutErrNextS;
        end
    end

    // Saturating count of held cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCntR <= {STALL_CNT_W{1'b0}};
        end else if (holdS && (stallCntR != STALL_MAX)) begin
            stallCntR <= stallCntR + STALL_CNT_W'(1);
        end else begin
            stallCntR <= stallCntR;
        end
    end

endmodule

// File: tb/tb_pipeline_mode_ctrl.sv
// Scoreboard bench for pipeline_mode_ctrl: per-cycle expectations are queued as stimulus
// is applied and compared against the DUT outputs half a cycle after each rising edge.
module tb_pipeline_mode_ctrl;

    logic clk = 1'b0;
    logic rst, branch_jump, ram_ready, reg_write_collision, load_req, load_done;

    logic       mh0, fh0, la0, te0;
    logic [1:0] md0;
    logic [3:0] st0;
    logic       mh1, fh1, la1, te1;
    logic [1:0] md1;
    logic [15:0] st1;

    logic [9:0] obs;
    logic [4:0] obs1;
    logic [9:0] sbq [$];
    logic [4:0] sbq1 [$];
    logic [9:0] expv;
    logic [4:0] expv1;
    logic [3:0] stallExp;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_mode_ctrl #(.FLUSH_CYCLES(3), .MEMWAIT_TIMEOUT(8), .STALL_CNT_W(4), .BOOT_LOAD(1'b1)) dut (
        .clk(clk), .rst(rst), .branch_jump(branch_jump), .ram_ready(ram_ready),
        .reg_write_collision(reg_write_collision), .load_req(load_req), .load_done(load_done),
        .master_hold(mh0), .flush_hold(fh0), .load_active(la0), .timeout_err(te0),
        .mode(md0), .stall_cycles(st0));

    pipeline_mode_ctrl #(.FLUSH_CYCLES(1), .MEMWAIT_TIMEOUT(1024), .STALL_CNT_W(16), .BOOT_LOAD(1'b0)) dut1 (
        .clk(clk), .rst(rst), .branch_jump(branch_jump), .ram_ready(ram_ready),
        .reg_write_collision(reg_write_collision), .load_req(load_req), .load_done(load_done),
        .master_hold(mh1), .flush_hold(fh1), .load_active(la1), .timeout_err(te1),
        .mode(md1), .stall_cycles(st1));

    assign obs  = {md0, mh0, fh0, la0, te0, st0};
    assign obs1 = {md1, mh1, fh1, la1};

    // stim bits: {branch_jump, ram_ready, reg_write_collision, load_req, load_done}
    task automatic apply(input logic [4:0] s);
        {branch_jump, ram_ready, reg_write_collision, load_req, load_done} = s;
        #1;
    endtask

    // Expected flush/load flags follow from the mode; the stall count from the expected holds.
    task automatic push(input logic [1:0] m, input logic mh, input logic te);
        sbq.push_back({m, mh, (m == 2'b01), (m == 2'b11), te, stallExp});
        if (mh && stallExp != 4'hF) stallExp = stallExp + 4'd1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        {branch_jump, ram_ready, reg_write_collision, load_req, load_done} = 5'b01000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        stallExp = 4'd0;
    endtask

    task automatic boot();
        doReset();
        apply(5'b01001);
        @(negedge clk);
        repeat (3) begin
            apply(5'b01000);
            @(negedge clk);
        end
        stallExp = 4'd1;
    endtask

    task automatic test_reset();
        logic [4:0] stim [10];
        logic [3:0] ex [10];
        doReset();
        for (int c = 0; c < 10; c++) begin
            stim[c] = (c == 5) ? 5'b01001 : 5'b01000;
            ex[c]   = (c <= 5) ? 4'b1110 : ((c <= 8) ? 4'b0100 : 4'b0000);
        end
        for (int c = 0; c < 10; c++) begin
            apply(stim[c]);
            push(ex[c][3:2], ex[c][1], ex[c][0]);
            expv = sbq.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL boot_seq c%0d: got %b want %b", c, obs, expv);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch_flush();
        logic [4:0] stim [5] = '{5'b11000, 5'b01000, 5'b01000, 5'b01000, 5'b01000};
        logic [3:0] ex [5]   = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        boot();
        for (int c = 0; c < 5; c++) begin
            apply(stim[c]);
            push(ex[c][3:2], ex[c][1], ex[c][0]);
            expv = sbq.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL branch_flush c%0d: got %b want %b", c, obs, expv);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_memwait_branch();
        logic [4:0] stim [16] = '{5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b01000, 5'b01000,
                                  5'b01000, 5'b01000, 5'b01000, 5'b00000, 5'b10000, 5'b01000,
                                  5'b01000, 5'b01000, 5'b01000, 5'b01000};
        logic [3:0] ex [16]   = '{4'b0010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0100,
                                  4'b0100, 4'b0100, 4'b0000, 4'b0010, 4'b1010, 4'b1010,
                                  4'b0100, 4'b0100, 4'b0100, 4'b0000};
        for (int c = 0; c < 16; c++) begin
            apply(stim[c]);
            push(ex[c][3:2], ex[c][1], ex[c][0]);
            expv = sbq.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL memwait_branch c%0d: got %b want %b", c, obs, expv);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_collision();
        logic [4:0] stim [4] = '{5'b01100, 5'b01100, 5'b01000, 5'b01000};
        logic [3:0] ex [4]   = '{4'b0010, 4'b0010, 4'b0000, 4'b0000};
        for (int c = 0; c < 4; c++) begin
            apply(stim[c]);
            push(ex[c][3:2], ex[c][1], ex[c][0]);
            expv = sbq.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL collision c%0d: got %b want %b", c, obs, expv);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_flush_exit_load();
        logic [4:0] stim [12] = '{5'b11000, 5'b01000, 5'b00000, 5'b00010, 5'b11000, 5'b01010,
                                  5'b00010, 5'b01011, 5'b01000, 5'b01000, 5'b01000, 5'b01000};
        logic [3:0] ex [12]   = '{4'b0000, 4'b0100, 4'b0110, 4'b0110, 4'b0100, 4'b0100,
                                  4'b1110, 4'b1110, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        boot();
        for (int c = 0; c < 12; c++) begin
            apply(stim[c]);
            push(ex[c][3:2], ex[c][1], ex[c][0]);
            expv = sbq.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL flush_exit_load c%0d: got %b want %b", c, obs, expv);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall_sat();
        boot();
        for (int c = 0; c < 22; c++) begin
            apply((c < 20) ? 5'b01100 : 5'b01000);
            push(2'b00, (c < 20), 1'b0);
            expv = sbq.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL stall_sat c%0d: got %b want %b", c, obs, expv);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        logic [4:0] stim [13];
        logic [3:0] ex [13];
        boot();
        for (int c = 0; c < 13; c++) begin
            stim[c] = (c < 10) ? 5'b00000 : 5'b01000;
            ex[c]   = (c == 0) ? 4'b0010 : (c <= 8) ? 4'b1010 : (c <= 10) ? 4'b1011 : 4'b0001;
        end
        for (int c = 0; c < 13; c++) begin
            apply(stim[c]);
            push(ex[c][3:2], ex[c][1], ex[c][0]);
            expv = sbq.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL timeout c%0d: got %b want %b", c, obs, expv);
            end
            @(negedge clk);
        end
    endtask

    // Continues from the sticky-timeout state left by test_timeout.
    task automatic test_rst_mid_flush();
        logic [4:0] stim [2] = '{5'b11000, 5'b01000};
        logic [3:0] ex [2]   = '{4'b0001, 4'b0101};
        for (int c = 0; c < 2; c++) begin
            apply(stim[c]);
            push(ex[c][3:2], ex[c][1], ex[c][0]);
            expv = sbq.pop_front();
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL rst_mid_flush c%0d: got %b want %b", c, obs, expv);
            end
            if (c == 0) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1;
        stallExp = 4'd0;
        push(2'b11, 1'b1, 1'b0);
        expv = sbq.pop_front();
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL rst_mid_flush async: got %b want %b", obs, expv);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_flush1();
        logic [4:0] stim [4] = '{5'b11000, 5'b01000, 5'b01000, 5'b00000};
        logic [4:0] ex [4]   = '{5'b00000, 5'b01010, 5'b00000, 5'b00100};
        doReset();
        for (int c = 0; c < 4; c++) begin
            apply(stim[c]);
            sbq1.push_back(ex[c]);
            expv1 = sbq1.pop_front();
            checks++;
            if (obs1 !== expv1) begin
                errors++;
                $display("FAIL flush1_noboot c%0d: got %b want %b", c, obs1, expv1);
            end
            @(negedge clk);
        end
        checks++;
        if (st1 !== 16'd1) begin
            errors++;
            $display("FAIL flush1_stall: got %0d want 1", st1);
        end
    endtask

    initial begin
        rst = 1'b1;
        stallExp = 4'd0;
        test_reset();
        test_branch_flush();
        test_memwait_branch();
        test_collision();
        test_flush_exit_load();
        test_stall_sat();
        test_timeout();
        test_rst_mid_flush();
        test_flush1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
